// File: rtl/aes_core_param.sv
// aes_core_param: iterative AES encryptor, one round per clock, cached key schedule.
// Optional AES_ZEROIZE_EN adds a synchronous zeroize input that wipes all key/data state.
module aes_core_param #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef AES_ZEROIZE_EN
    input  logic                zeroize,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                new_key,
    input  logic [KEY_BITS-1:0] key,
    input  logic [127:0]        state,
    output logic [127:0]        out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam int AW = 6;

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_core_param: KEY_BITS must be 128, 192 or 256");
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            p = b[k] ? p ^ x : p;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, so 0 maps to 0) followed by the affine map
    function automatic logic [7:0] sb(input logic [7:0] a);
        logic [7:0] s, v;
        s = a;
        v = 8'h01;
        for (int k = 1; k < 8; k++) begin
            s = gmul(s, s);
            v = gmul(v, s);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sw(input logic [31:0] x);
        return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
    endfunction

    // Byte 4*c+r is column c, row r; ShiftRows pulls row r from column (c+r)%4
    function automatic logic [127:0] rnd(input logic [127:0] s, input logic nomix);
        logic [7:0]   b [16];
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[4*c+r] = sb(s[127-8*(4*((c+r)%4)+r) -: 8]);
        for (int c = 0; c < 4; c++)
            o[127-32*c -: 32] = nomix ? {b[4*c], b[4*c+1], b[4*c+2], b[4*c+3]} :
                {xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3],
                 b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3],
                 b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3],
                 xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3])};
        return o;
    endfunction

    typedef enum logic [2:0] {IDLE, KEYEXP, ARK0, ROUND, DONE} fsm_t;

    fsm_t          fsm, fsm_n;
    logic [31:0]   w [NW];
    logic [127:0]  st, rk, nxt;
    logic [AW-1:0] wi, rb;
    logic [AW-3:0] rn;
    logic [2:0]    wk;
    logic [7:0]    rcon;
    logic [31:0]   wp, wn;
    logic          key_loaded, eff_new, last, zz;

`ifdef AES_ZEROIZE_EN
    assign zz = zeroize;
`else
    assign zz = 1'b0;
`endif

    assign in_ready = rst_n && fsm == IDLE;
    assign busy     = fsm != IDLE;
    assign eff_new  = new_key || !key_loaded;

    // wk tracks wi mod NK so no divider is needed for the Rcon/SubWord selection
    assign wp = w[wi - AW'(1)];
    assign wn = w[wi - AW'(NK)] ^ (wk == 3'd0 ? sw({wp[23:0], wp[31:24]}) ^ {rcon, 24'h0} :
                                   (NK == 8 && wk == 3'd4) ? sw(wp) : wp);

    assign rb   = {rn, 2'b00};
    assign rk   = {w[rb], w[rb | AW'(1)], w[rb | AW'(2)], w[rb | AW'(3)]};
    assign last = rn == (AW-2)'(NR);
    assign nxt  = rnd(st, last) ^ rk;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) fsm <= IDLE;
        else fsm <= fsm_n;

    always_comb begin
        fsm_n = fsm;
        if (zz) fsm_n = IDLE;
        else case (fsm)
            IDLE:    if (in_valid) fsm_n = eff_new ? KEYEXP : ARK0;
            KEYEXP:  if (wi == AW'(NW - 1)) fsm_n = ARK0;
            ARK0:    fsm_n = ROUND;
            ROUND:   if (last) fsm_n = DONE;
            DONE:    if (out_ready) fsm_n = IDLE;
            default: fsm_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NW; j++) w[j] <= '0;
            st         <= '0;
            out        <= '0;
            out_valid  <= 1'b0;
            key_loaded <= 1'b0;
            wi         <= '0;
            wk         <= '0;
            rcon       <= 8'h01;
            rn         <= '0;
        end else if (zz) begin
            for (int j = 0; j < NW; j++) w[j] <= '0;
            st         <= '0;
            out        <= '0;
            out_valid  <= 1'b0;
            key_loaded <= 1'b0;
        end else begin
            case (fsm)
                IDLE: if (in_valid) begin
                    st <= state;
                    rn <= '0;
                    if (eff_new) begin
                        for (int j = 0; j < NK; j++) w[j] <= key[KEY_BITS-1-32*j -: 32];
                        wi   <= AW'(NK);
                        wk   <= '0;
                        rcon <= 8'h01;
                    end
                end
                KEYEXP: begin
                    w[wi]      <= wn;
                    wi         <= wi + AW'(1);
                    wk         <= wk == 3'(NK - 1) ? 3'd0 : wk + 3'd1;
                    rcon       <= wk == 3'd0 ? xt(rcon) : rcon;
                    key_loaded <= key_loaded || wi == AW'(NW - 1);
                end
                ARK0: begin
                    st <= st ^ rk;
                    rn <= (AW-2)'(1);
                end
                ROUND: begin
                    st <= nxt;
                    rn <= last ? rn : rn + (AW-2)'(1);
                    if (last) begin
                        out       <= nxt;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_core_param.sv
// tb_aes_core_param: scoreboard bench driving FIPS-197 vectors into 128/192/256-bit instances.
module tb_aes_core_param;
    typedef struct { logic [127:0] ct; int lat; int t0; } exp_t;

    localparam logic [127:0] K_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K_C    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [191:0] K_192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] K_256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst_n, zexp = 1'b0, fin = 1'b0, one = 1'b1;
    logic         iv1, ir1, nk1, ov1, or1, b1;
    logic [127:0] k1, pt1, o1;
    logic         iv2, ir2, nk2, ov2, b2;
    logic [191:0] k2;
    logic [127:0] pt2, o2;
    logic         iv3, ir3, nk3, ov3, b3;
    logic [255:0] k3;
    logic [127:0] pt3, o3;
`ifdef AES_ZEROIZE_EN
    logic         zz = 1'b0;
`endif

    int   cyc = 0, pass = 0, tot = 0;
    exp_t q1[$], q2[$], q3[$];
    logic [127:0] held = '0;
    logic pv1 = 1'b0, pv2 = 1'b0, pv3 = 1'b0, prst = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_core_param #(.KEY_BITS(128)) u128 (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_ZEROIZE_EN
        .zeroize(zz),
`endif
        .in_valid(iv1), .in_ready(ir1), .new_key(nk1), .key(k1), .state(pt1),
        .out(o1), .out_valid(ov1), .out_ready(or1), .busy(b1));

    aes_core_param #(.KEY_BITS(192)) u192 (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_ZEROIZE_EN
        .zeroize(zz),
`endif
        .in_valid(iv2), .in_ready(ir2), .new_key(nk2), .key(k2), .state(pt2),
        .out(o2), .out_valid(ov2), .out_ready(one), .busy(b2));

    aes_core_param #(.KEY_BITS(256)) u256 (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_ZEROIZE_EN
        .zeroize(zz),
`endif
        .in_valid(iv3), .in_ready(ir3), .new_key(nk3), .key(k3), .state(pt3),
        .out(o3), .out_valid(ov3), .out_ready(one), .busy(b3));

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        tot++;
        if (a === e) pass++;
        else $display("FAIL %s: got %h, want %h", n, a, e);
    endtask

    // Monitor: pops the scoreboard on every out_valid rise and checks the handshake around it
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out", o1, '0);
            chk("rst_valid", 128'(ov1), '0);
            chk("rst_busy", 128'(b1), '0);
            q1.delete();
        end else begin
            if (!prst) chk("rdy_after_rst", 128'(ir1), 128'(1));
            if (ov1 && !pv1) begin
                if (q1.size() == 0) chk("spurious_out128", 128'(q1.size()), 128'(1));
                else begin
                    chk("ct128", o1, q1[0].ct);
                    chk("lat128", 128'(cyc - q1[0].t0), 128'(q1[0].lat));
                    chk("busy_rdy128", 128'({b1, ir1}), 128'(2'b10));
                    void'(q1.pop_front());
                end
                held <= o1;
            end
            if (ov1 && pv1) begin
                chk("hold_out", o1, held);
                chk("hold_rdy", 128'(ir1), '0);
            end
            if (!ov1 && pv1) begin
                chk("ack_rdy", 128'(ir1), 128'(1));
                chk("ack_out", o1, zexp ? '0 : held);
            end
            if (ov2 && !pv2) begin
                if (q2.size() == 0) chk("spurious_out192", 128'(q2.size()), 128'(1));
                else begin
                    chk("ct192", o2, q2[0].ct);
                    chk("lat192", 128'(cyc - q2[0].t0), 128'(q2[0].lat));
                    chk("busy_rdy192", 128'({b2, ir2}), 128'(2'b10));
                    void'(q2.pop_front());
                end
            end
            if (ov3 && !pv3) begin
                if (q3.size() == 0) chk("spurious_out256", 128'(q3.size()), 128'(1));
                else begin
                    chk("ct256", o3, q3[0].ct);
                    chk("lat256", 128'(cyc - q3[0].t0), 128'(q3[0].lat));
                    chk("busy_rdy256", 128'({b3, ir3}), 128'(2'b10));
                    void'(q3.pop_front());
                end
            end
            if (fin) begin
                chk("pending128", 128'(q1.size()), '0);
                chk("pending192", 128'(q2.size()), '0);
                chk("pending256", 128'(q3.size()), '0);
            end
        end
        pv1  <= ov1;
        pv2  <= ov2;
        pv3  <= ov3;
        prst <= rst_n;
    end

    // Leaves in_valid high on return so a following call exercises back-to-back transfers
    task automatic send(input logic [127:0] k, input logic [127:0] p, input logic n,
                        input logic [127:0] ct, input int lat);
        k1 = k;
        pt1 = p;
        nk1 = n;
        iv1 = 1'b1;
        @(negedge clk);
        for (int t = 0; !ir1; t++) begin
            if (t > 300) begin
                $display("FAIL send_timeout: in_ready low for %0d cycles, want high", t);
                $fatal(1);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 q1.push_back('{ct, lat, cyc});
    endtask

    task automatic wait_ov();
        for (int t = 0; !ov1; t++) begin
            if (t > 300) begin
                $display("FAIL out_valid_timeout: out_valid low for %0d cycles, want high", t);
                $fatal(1);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        iv1 = 1'b0; nk1 = 1'b0; k1 = '0; pt1 = '0; or1 = 1'b1;
        iv2 = 1'b0; nk2 = 1'b1; k2 = K_192; pt2 = PT_C;
        iv3 = 1'b0; nk3 = 1'b1; k3 = K_256; pt3 = PT_C;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        iv2 = 1'b1;
        iv3 = 1'b1;
        @(posedge clk);
        #1 q2.push_back('{CT_192, 59, cyc});
        q3.push_back('{CT_256, 67, cyc});
        iv2 = 1'b0;
        iv3 = 1'b0;
        // out_ready already high; in_valid stays high across the first three blocks
        send(K_B, PT_B, 1'b1, CT_B, 51);
        send(K_C, PT_C, 1'b1, CT_C, 51);
        send('1, PT_C, 1'b0, CT_C, 11);
        iv1 = 1'b0;
        or1 = 1'b0;
        wait_ov();
        repeat (20) @(negedge clk);
        or1 = 1'b1;
        @(posedge clk);
        #1 or1 = 1'b0;
        // reset during the fifth round discards the block and the cached schedule
        send(K_C, PT_C, 1'b0, CT_C, 11);
        iv1 = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        or1 = 1'b1;
        send(K_C, PT_C, 1'b0, CT_C, 51);
        iv1 = 1'b0;
        wait_ov();
        @(posedge clk);
        #1;
`ifdef AES_ZEROIZE_EN
        or1 = 1'b0;
        send(K_C, PT_C, 1'b0, CT_C, 11);
        iv1 = 1'b0;
        wait_ov();
        zexp = 1'b1;
        zz = 1'b1;
        @(posedge clk);
        #1 zz = 1'b0;
        @(negedge clk);
        #1 zexp = 1'b0;
        or1 = 1'b1;
        send(K_C, PT_C, 1'b0, CT_C, 51);
        iv1 = 1'b0;
        wait_ov();
        @(posedge clk);
        #1;
`endif
        fin = 1'b1;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end
endmodule

// File: doc/aes_core_param.md
Name: aes_core_param

Overview:
- Iterative AES encryption core, one round per clock.
- Key length is selected by parameter: 128, 192 or 256 bits.
- Expanded key schedule is cached, so back-to-back blocks under one key skip re-expansion.
- Successor to the fixed aes_128 core. Adds a valid/ready handshake on input and output, async reset, and key reuse. Sits between the fuzzing harness and the cipher datapath.

Parameters:
- KEY_BITS, 128, key length. Legal values are 128, 192, 256; any other value is an elaboration error. Nk = KEY_BITS/32 and Nr = Nk+6.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  plaintext/key offered
- in_ready  out  1  core can accept
- new_key  in  1  expand key on this transfer
- key  in  KEY_BITS  cipher key, FIPS-197 byte order, first byte in MSBs
- state  in  128  plaintext, first byte in MSBs
- out  out  128  ciphertext
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0, takes effect immediately):
  - FSM goes to IDLE; key_loaded=0.
  - out=0, out_valid=0, busy=0; in_ready=1 once rst_n is released.
  - Round-key storage and the state register are cleared to 0.
  - An operation in flight is discarded and no output is produced.
- Input transfer: occurs on the edge where in_valid && in_ready. in_ready=1 only in IDLE.
  - Registers state, key and new_key.
  - new_key=0 while key_loaded=0 is treated as new_key=1.
- FSM states: IDLE, KEYEXP, ARK0, ROUND, DONE.
  - IDLE -> KEYEXP on transfer with an effective new_key; otherwise IDLE -> ARK0.
  - KEYEXP: first Nk words w[0..Nk-1] are loaded from key at the transfer edge. Then one word w[i] per cycle for i = Nk..4(Nr+1)-1, using standard RotWord/SubWord/Rcon. SubWord-only applies when Nk=8 and i mod 8 = 4. This takes E = 4(Nr+1)-Nk cycles: 40, 46 or 52. Sets key_loaded=1 when done, then -> ARK0.
  - ARK0: st <= pt ^ rk[0]; round counter r=1; -> ROUND.
  - ROUND: st <= MixColumns(ShiftRows(SubBytes(st))) ^ rk[r]. MixColumns is omitted when r=Nr. r increments; when r=Nr, registers st into out, sets out_valid=1 and goes -> DONE.
  - DONE: out and out_valid are held stable until out_ready=1. On that edge out_valid=0 -> IDLE; out keeps its value.
- Latency from transfer edge to out_valid rising:
  - New key: E+1+Nr = 51 / 59 / 67 cycles for 128 / 192 / 256.
  - Reused key: 1+Nr = 11 / 13 / 15 cycles.
- Input changes while busy are ignored; pt and key are captured only at the transfer.
- in_valid held high continuously: the next transfer happens on the edge after the DONE handshake, when in_ready rises.
- out_ready high before out_valid is legal and has no effect.
- new_key=1 with the same key value re-expands anyway. No comparison is made.

Optional Feature:
- Macro: AES_ZEROIZE_EN.
- Defined: adds input port zeroize (1 bit, synchronous). When high on an edge in any state:
  - Clears the round keys, st, out and key_loaded.
  - Drops out_valid.
  - Forces IDLE.
  - Takes priority over the input transfer and over out_ready.
- Undefined: port absent. Key material persists until reset.

Test Plan:
- KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, new_key=1 -> out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid rises 51 cycles after the transfer.
- KEY_BITS=192, key 000102…1617, same pt -> out dda97ca4864cdfe06eaf70a0ec0d7191 after 59 cycles. KEY_BITS=256, key 000102…1e1f -> out 8ea2b7ca516745bfeafc49904b496089 after 67 cycles.
- KEY_BITS=128: second block with new_key=0, same pt, key port driven to ffff…ff -> same ciphertext 69c4e0d8…c55a after 11 cycles.
- Hold out_ready=0 for 20 cycles after out_valid -> out stable, in_ready=0 throughout. Pulse out_ready -> out_valid=0 and in_ready=1 on the next cycle.
- Assert rst_n=0 mid-ROUND (cycle 5 of 10) -> out=0, out_valid=0, busy=0 immediately. Next block with new_key=0 re-expands, giving 51-cycle latency.
- With AES_ZEROIZE_EN: pulse zeroize in DONE -> out=0, out_valid=0, IDLE. Next new_key=0 block re-expands and matches the FIPS vector.
